// File: rtl/demux_router.sv
// demux_router
//   Sequential 1-to-NOUT demultiplexer. A single valid/ready word stream,
//   tagged with a 2-bit destination select, is steered into one of NOUT
//   per-channel 2-entry FIFOs. A stalled channel blocks only the words
//   addressed to it. Words addressed to a non-existent channel
//   (in_sel >= NOUT) are accepted, discarded and reported on drop.
//
// Parameters
//   WIDTH      data word width (default 16)
//   NOUT       number of output channels, 1..4 (default 4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers a word
//   in_ready   word is accepted this cycle (depends on in_sel and
//              registered occupancy only; no path from out_ready)
//   in_data    offered word
//   in_sel     destination channel index
//   out_valid  bit k: channel k head word is valid
//   out_ready  bit k: consumer k takes the head word
//   out_data   channel k head word at [k*WIDTH +: WIDTH]
//   drop       one-cycle pulse after a word addressed to in_sel >= NOUT
//              was consumed
//   out_count  per-channel saturating 16-bit delivered-word counters,
//              [k*16 +: 16]; present only when DEMUX_ROUTER_COUNT_EN is
//              defined
//
// Build option
//   DEMUX_ROUTER_COUNT_EN  adds the per-channel pop counters and out_count.

module demux_router #(
  parameter int WIDTH = 16,
  parameter int NOUT  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [1:0]              in_sel,
  output logic [NOUT-1:0]         out_valid,
  input  logic [NOUT-1:0]         out_ready,
  output logic [NOUT*WIDTH-1:0]   out_data,
  output logic                    drop
`ifdef DEMUX_ROUTER_COUNT_EN
  ,
  output logic [NOUT*16-1:0]      out_count
`endif
);

  // Channel count widened by one bit so in_sel can be compared against 4.
  localparam logic [2:0] NOUT_W = 3'(NOUT);

  logic [1:0] occ_s [NOUT];
  logic       ready_s;
  logic       accept_s;
  logic       discard_s;
  logic       drop_r;

  // A word for a non-existent channel is always accepted and thrown away.
  assign discard_s = in_valid && ({1'b0, in_sel} >= NOUT_W);

  // Ready is high unless the addressed channel is full; unknown selects
  // match no channel and therefore stay ready.
  always_comb begin
    ready_s = 1'b1;
    for (int k = 0; k < NOUT; k++) begin
      if (in_sel == k[1:0]) begin
        ready_s = (occ_s[k] != 2'd2);
      end else begin
        ready_s = ready_s;
      end
    end
  end

  assign in_ready = ready_s;
  assign accept_s = in_valid && ready_s;

  // Drop pulse register: high for the cycle following each discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_r <= 1'b0;
    end else begin
      drop_r <= discard_s;
    end
  end

  assign drop = drop_r;

  for (genvar k = 0; k < NOUT; k++) begin : g_ch
    localparam logic [1:0] CH = 2'(k);

    logic [WIDTH-1:0] ent0_r;
    logic [WIDTH-1:0] ent1_r;
    logic             wptr_r;
    logic             rptr_r;
    logic [1:0]       occ_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = accept_s && (in_sel == CH);
    assign pop_s  = (occ_r != 2'd0) && out_ready[k];

    // Channel FIFO: two entries, toggling pointers, occupancy 0..2.
    // Push and pop together leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ent0_r <= {WIDTH{1'b0}};
        ent1_r <= {WIDTH{1'b0}};
        wptr_r <= 1'b0;
        rptr_r <= 1'b0;
        occ_r  <= 2'd0;
      end else begin
        if (push_s) begin
          if (wptr_r) begin
            ent1_r <= in_data;
          end else begin
            ent0_r <= in_data;
          end
          wptr_r <= ~wptr_r;
        end
        if (pop_s) begin
          rptr_r <= ~rptr_r;
        end
        case ({push_s, pop_s})
          2'b10:   occ_r <= occ_r + 2'd1;
          2'b01:   occ_r <= occ_r - 2'd1;
          default: occ_r <= occ_r;
        endcase
      end
    end

    assign occ_s[k]                     = occ_r;
    assign out_valid[k]                 = (occ_r != 2'd0);
    assign out_data[k*WIDTH +: WIDTH]   = rptr_r ? ent1_r : ent0_r;

`ifdef DEMUX_ROUTER_COUNT_EN
    logic [15:0] cnt_r;

    // Delivered-word counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= 16'd0;
      end else if (pop_s && (cnt_r != 16'hFFFF)) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign out_count[k*16 +: 16] = cnt_r;
`endif
  end

endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main instance, NOUT = 4
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic [1:0]  in_sel = 2'd0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'd0;
  logic [63:0] out_data;
  logic        drop;

  // Second instance, NOUT = 3, for the discard path
  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [15:0] in_data3 = 16'd0;
  logic [1:0]  in_sel3 = 2'd0;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3 = 3'b111;
  logic [47:0] out_data3;
  logic        drop3;

`ifdef DEMUX_ROUTER_COUNT_EN
  logic [63:0] out_count;
  logic [47:0] out_count3;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: one bounded queue (capacity 2) per channel.
  logic [15:0] q [4][$];
  logic        exp_drop = 1'b0;
  int          cnt_exp [4];

  always #5 clk = ~clk;

  demux_router #(.WIDTH(16), .NOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop(drop)
`ifdef DEMUX_ROUTER_COUNT_EN
    , .out_count(out_count)
`endif
  );

  demux_router #(.WIDTH(16), .NOUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .drop(drop3)
`ifdef DEMUX_ROUTER_COUNT_EN
    , .out_count(out_count3)
`endif
  );

  function automatic logic exp_ready(input logic [1:0] s);
    return (q[s].size() < 2);
  endfunction

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (q[k].size() != 0);
    return v;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      cnt_exp[k] = 0;
    end
    exp_drop = 1'b0;
  endfunction

  // Apply inputs at the falling edge, let combinational paths settle.
  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d,
                       input logic [3:0] ordy);
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Advance one rising edge and update the model from the inputs in force.
  task automatic tick();
    logic       pv;
    logic [3:0] pops;
    pv = in_valid && exp_ready(in_sel);
    for (int k = 0; k < 4; k++) pops[k] = (q[k].size() != 0) && out_ready[k];
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (pops[k]) begin
        void'(q[k].pop_front());
        if (cnt_exp[k] < 65535) cnt_exp[k]++;
      end
    end
    if (pv) q[in_sel].push_back(in_data);
    exp_drop = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 4'b0000);
    end
    checks++;
    if (out_data !== 64'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=%h", out_data, 64'd0);
    end
    checks++;
    if (drop !== 1'b0 || drop3 !== 1'b0) begin
      failures++; $display("FAIL reset_drop got=%b%b exp=00", drop, drop3);
    end
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); in_valid = 1'b1; #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL reset_ready sel=%0d got=%b exp=1", s, in_ready);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_routing();
    logic [15:0] w;
    for (int s = 0; s < 4; s++) begin
      w = 16'hA000 + 16'(s);
      drive(1'b1, 2'(s), w, 4'hF);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL route_ready sel=%0d got=%b exp=1", s, in_ready);
      end
      tick();
      #1;
      checks++;
      if (out_valid !== (4'b0001 << s) || out_valid !== exp_valid()) begin
        failures++; $display("FAIL route_valid sel=%0d got=%b exp=%b", s, out_valid, 4'b0001 << s);
      end
      checks++;
      if (out_data[s*16 +: 16] !== w) begin
        failures++; $display("FAIL route_data sel=%0d got=%h exp=%h", s, out_data[s*16 +: 16], w);
      end
    end
    drive(1'b0, 2'd0, 16'd0, 4'hF);
    tick();
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL route_drain got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd1, 16'h0001, 4'b1101); tick();
    drive(1'b1, 2'd1, 16'h0002, 4'b1101);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_second_ready got=%b exp=1", in_ready);
    end
    tick();
    drive(1'b1, 2'd1, 16'h0003, 4'b1101);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready);
    end
    tick();
    // Raising out_ready must not make in_ready rise in the same cycle.
    drive(1'b1, 2'd1, 16'h0003, 4'b1111);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_no_comb_path got=%b exp=0", in_ready);
    end
    checks++;
    if (out_data[31:16] !== 16'h0001) begin
      failures++; $display("FAIL bp_head1 got=%h exp=0001", out_data[31:16]);
    end
    tick();
    drive(1'b1, 2'd1, 16'h0003, 4'b1111);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready);
    end
    checks++;
    if (out_data[31:16] !== 16'h0002) begin
      failures++; $display("FAIL bp_head2 got=%h exp=0002", out_data[31:16]);
    end
    tick();
    drive(1'b0, 2'd0, 16'd0, 4'b1111);
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[31:16] !== 16'h0003) begin
      failures++; $display("FAIL bp_head3 got=%b/%h exp=1/0003", out_valid[1], out_data[31:16]);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== exp_valid()) begin
      failures++; $display("FAIL bp_drain got=%b exp=%b", out_valid, exp_valid());
    end
  endtask

  task automatic test_isolation();
    drive(1'b1, 2'd0, 16'hC000, 4'b0000); tick();
    drive(1'b1, 2'd0, 16'hC001, 4'b0000); tick();
    drive(1'b1, 2'd0, 16'hC002, 4'b0000);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL iso_ch0_full got=%b exp=0", in_ready);
    end
    drive(1'b1, 2'd3, 16'hBEEF, 4'b0000);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL iso_ready3 got=%b exp=1", in_ready);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 4'b1001 || out_data[63:48] !== 16'hBEEF) begin
      failures++; $display("FAIL iso_deliver got=%b/%h exp=1001/beef", out_valid, out_data[63:48]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd0, 16'd0, 4'hF); tick();
    end
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL iso_drain got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_drop();
    @(negedge clk);
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 16'hDEAD; #1;
    checks++;
    if (in_ready3 !== 1'b1) begin
      failures++; $display("FAIL drop_ready got=%b exp=1", in_ready3);
    end
    @(negedge clk);
    checks++;
    if (drop3 !== 1'b1 || out_valid3 !== 3'b000) begin
      failures++; $display("FAIL drop_pulse got=%b/%b exp=1/000", drop3, out_valid3);
    end
    // Second back-to-back discard keeps drop high.
    in_data3 = 16'hDEAE;
    @(negedge clk);
    checks++;
    if (drop3 !== 1'b1) begin
      failures++; $display("FAIL drop_b2b got=%b exp=1", drop3);
    end
    in_valid3 = 1'b0;
    @(negedge clk);
    checks++;
    if (drop3 !== 1'b0 || out_valid3 !== 3'b000) begin
      failures++; $display("FAIL drop_end got=%b/%b exp=0/000", drop3, out_valid3);
    end
    checks++;
    if (drop !== 1'b0) begin
      failures++; $display("FAIL drop_main got=%b exp=0", drop);
    end
  endtask

  task automatic test_random();
    logic        v;
    logic [1:0]  s;
    logic [15:0] d;
    logic [3:0]  r;
    int          bad;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 3) != 0);
      s = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      r = 4'($urandom);
      drive(v, s, d, r);
      checks++;
      if (in_ready !== exp_ready(s)) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_ready(s));
      end
      checks++;
      if (out_valid !== exp_valid()) begin
        failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, exp_valid());
      end
      bad = 0;
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() != 0 && out_data[k*16 +: 16] !== q[k][0]) bad = bad + 1;
      end
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL rand_data cyc=%0d got=%h mismatching_channels=%0d exp=0", i, out_data, bad);
      end
      checks++;
      if (drop !== exp_drop) begin
        failures++; $display("FAIL rand_drop cyc=%0d got=%b exp=%b", i, drop, exp_drop);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd0, 16'd0, 4'hF); tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd2, 16'h1111, 4'b0000); tick();
    drive(1'b1, 2'd2, 16'h2222, 4'b0000); tick();
    drive(1'b0, 2'd2, 16'd0, 4'b0000);
    checks++;
    if (out_valid !== 4'b0100 || out_data[47:32] !== 16'h1111) begin
      failures++; $display("FAIL rstmid_filled got=%b/%h exp=0100/1111", out_valid, out_data[47:32]);
    end
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL rstmid_async_valid got=%b exp=0000", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd2, 16'd0, 4'hF); tick();
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++; $display("FAIL rstmid_stale got=%b exp=0000", out_valid);
    end
  endtask

`ifdef DEMUX_ROUTER_COUNT_EN
  task automatic test_counter();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 16'(16'h5000 + i), 4'hF); tick();
    end
    drive(1'b0, 2'd0, 16'd0, 4'hF); tick();
    #1;
    checks++;
    if (out_count[15:0] !== 16'(cnt_exp[0]) || out_count[15:0] !== 16'd5) begin
      failures++; $display("FAIL cnt_stream got=%0d exp=5", out_count[15:0]);
    end
    @(negedge clk);
    dut.g_ch[0].cnt_r = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 16'(16'h6000 + i), 4'hF); tick();
    end
    drive(1'b0, 2'd0, 16'd0, 4'hF); tick();
    #1;
    checks++;
    if (out_count[15:0] !== 16'hFFFF) begin
      failures++; $display("FAIL cnt_saturate got=%h exp=ffff", out_count[15:0]);
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_routing();
    test_backpressure();
    test_isolation();
    test_drop();
    test_random();
    test_reset_mid();
`ifdef DEMUX_ROUTER_COUNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_router.md
# demux_router

Sequential 1-to-N demultiplexer; the steering counterpart of the 2:1 multiplexor. It accepts a single valid/ready word stream tagged with a select field and delivers each word to one of NOUT output channels. Each channel has its own 2-entry buffer, so a stalled channel blocks only words addressed to it. The block sits between a shared producer, such as the CPU's memory-mapped write path, and independent peripheral consumers.

## Interface
- WIDTH, default 16: data word width in bits.
- NOUT, default 4: number of output channels; legal range 1..4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer offers a word.
- in_ready  out  1  block accepts the offered word this cycle.
- in_data  in  WIDTH  offered word.
- in_sel  in  2  destination channel index.
- out_valid  out  NOUT  bit k: channel k buffer head is valid.
- out_ready  in  NOUT  bit k: consumer k takes the head word.
- out_data  out  NOUT*WIDTH  channel k head word at bits [k*WIDTH +: WIDTH].
- drop  out  1  one-cycle pulse: a word addressed to in_sel >= NOUT was consumed and discarded.
- out_count  out  NOUT*16  per-channel delivered-word counters; present only with DEMUX_ROUTER_COUNT_EN.

## Operation
- Each channel k has a 2-entry FIFO: two data registers, a 1-bit write pointer, a 1-bit read pointer and a 2-bit occupancy (0..2).
- Push to channel k: in_valid && in_ready && in_sel == k.
- Pop from channel k: out_valid[k] && out_ready[k].
- in_ready = (in_sel >= NOUT) || (occ[in_sel] != 2).
  - Depends only on in_sel and registered occupancy. There is no combinational path from out_ready to in_ready.
- A word with in_sel >= NOUT is always accepted, written nowhere, and drop pulses high in the following cycle.
- out_valid[k] = (occ[k] != 0). out_data slice k = the entry at read pointer k.
- Simultaneous push and pop on the same channel:
  - Occupancy is unchanged and both pointers advance.
  - This is legal at occupancy 1, and at occupancy 2 only if the push was already allowed (i.e. never, because in_ready was 0).
- Pointers wrap 1 -> 0.
- in_data and in_sel are ignored when in_valid = 0.
- Reset (asynchronous, any time, including mid-transfer):
  - All occupancies, pointers and drop go to 0, so out_valid = 0. in_ready then equals 1 for every in_sel.
  - out_data resets to 0.
  - Buffered words are discarded.
  - Counters reset to 0.

## Timing
- Latency is 1 cycle: a word accepted at edge n is visible on out_valid and out_data after edge n.
- Throughput is 1 word per cycle per channel when out_ready[k] is held high. Occupancy then toggles between 0 and 1 and never reaches 2.
- Any channel can fill from empty in 2 cycles. After that, in_ready for that in_sel stays 0 until the first edge at which a pop occurs.
- drop is asserted for exactly the cycle after the discarding accept. Back-to-back discards keep drop high continuously.
- out_data for an empty channel holds its last value; consumers must qualify it with out_valid.

## Configuration
- DEMUX_ROUTER_COUNT_EN defined:
  - Each channel has a 16-bit counter that increments on every pop.
  - It saturates at 16'hFFFF and never wraps.
  - The counters are driven on out_count and reset to 0.
- DEMUX_ROUTER_COUNT_EN undefined: no counter logic and no out_count port. All other behaviour is identical.

## Test plan
- Reset mid-stream:
  - Stimulus: fill channel 2 with 16'h1111 and 16'h2222, then pulse rst_n low between edges.
  - Expected: out_valid = 4'b0000 immediately (asynchronous), in_ready = 1, and after release no stale word appears.
- Routing:
  - Stimulus: with all out_ready = 1, send 16'hA000, 16'hA001, 16'hA002, 16'hA003 to sel 0, 1, 2, 3 on consecutive cycles.
  - Expected: each appears on its own channel exactly 1 cycle after acceptance; the other out_valid bits stay 0.
- Full and backpressure:
  - Stimulus: with out_ready[1] = 0, send 16'h0001, 16'h0002, 16'h0003 to sel 1.
  - Expected: the first two words are accepted and in_ready drops to 0 on the third. Raising out_ready[1] pops 16'h0001 and then 16'h0002; 16'h0003 is accepted on the cycle after the first pop. Order is preserved.
- Isolation:
  - Stimulus: stall and fill channel 0, then send 16'hBEEF to sel 3.
  - Expected: in_ready = 1 for sel 3, and 16'hBEEF is delivered on channel 3 in 1 cycle.
- Drop:
  - Stimulus: set NOUT = 3 and send 16'hDEAD with sel 3.
  - Expected: in_ready = 1, drop pulses for exactly 1 cycle, and no out_valid bit rises.
- Counter (DEMUX_ROUTER_COUNT_EN):
  - Stimulus: stream 5 words to channel 0; separately, force channel 0's counter to 16'hFFFE and pop 3 words.
  - Expected: out_count[15:0] = 5 after the stream; in the forced case the counter reads 16'hFFFF and stays there.
